// File: rtl/falafel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : falafel_pkg
// Description : Shared allocator types. Heap words, the free-block header
//               layout, the null pointer, plus the free-list walker state
//               encoding and its result bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package falafel_pkg;

    typedef logic [31:0] word_t;

    // Header stored at the start of every free block.
    typedef struct packed {
        word_t size;
        word_t next_ptr;
    } free_block_t;

    localparam word_t NULL_PTR = '0;

    // Width of the hop field inside the result bundle. Sized for the default
    // walker hop limit; the walker resizes to its own counter width.
    localparam int WALK_HOPS_W = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } walker_state_e;

    typedef struct packed {
        logic                   found;
        word_t                  block_ptr;
        word_t                  prev_ptr;
        free_block_t            block;
        logic [WALK_HOPS_W-1:0] hops;
        logic                   abort;
    } walk_rsp_t;

endpackage : falafel_pkg
`default_nettype wire

// File: rtl/falafel_block_parser.sv
`default_nettype none
// ============================================================================
// Module      : falafel_block_parser
// Description : Purely combinational evaluation of one free-block header
//               against a requested allocation size.
// Ports       : i_block          - block header {size, next_ptr}
//               i_req_size       - requested size in bytes
//               o_is_big_enough  - block size >= request (unsigned)
//               o_is_null        - block is the last one in the list
//               o_next_block_ptr - pointer to the following block
// Revision    : 1.0 - initial release
// ============================================================================
module falafel_block_parser
    import falafel_pkg::*;
(
    input  free_block_t i_block,
    input  word_t       i_req_size,
    output logic        o_is_big_enough,
    output logic        o_is_null,
    output word_t       o_next_block_ptr
);

    // Full-width unsigned compare; an exact size match is a fit.
    assign o_is_big_enough  = (i_block.size >= i_req_size);
    assign o_is_null        = (i_block.next_ptr == NULL_PTR);
    assign o_next_block_ptr = i_block.next_ptr;

endmodule : falafel_block_parser
`default_nettype wire

// File: rtl/falafel_freelist_walker.sv
`default_nettype none
// ============================================================================
// Module      : falafel_freelist_walker
// Description : First-fit search over the singly linked free list. Reads one
//               block header at a time from heap memory and stops at the
//               first block large enough for the request or at list end.
//               Returns the found block and its predecessor for unlinking.
// Config      : FALAFEL_WALK_LIMIT_EN - when defined, a search that has
//               visited MAX_HOPS blocks without terminating is aborted
//               (rsp_abort_o = 1). Undefined: no limit, rsp_abort_o is 0.
// Ports       : clk_i, rst_ni            - clock, async active-low reset
//               req_*                    - search request (size, head ptr)
//               mem_req_* / mem_rsp_*    - heap header read port
//               rsp_*                    - search result to the consumer
// Revision    : 1.0 - initial release
// ============================================================================
module falafel_freelist_walker
    import falafel_pkg::*;
#(
    parameter int MAX_HOPS  = 1024,
    parameter int HOP_CNT_W = $clog2(MAX_HOPS + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  word_t                req_size_i,
    input  word_t                req_head_ptr_i,

    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output word_t                mem_req_addr_o,
    input  logic                 mem_rsp_valid_i,
    input  free_block_t          mem_rsp_block_i,

    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_found_o,
    output word_t                rsp_block_ptr_o,
    output word_t                rsp_prev_ptr_o,
    output free_block_t          rsp_block_o,
    output logic [HOP_CNT_W-1:0] rsp_hops_o,
    output logic                 rsp_abort_o
);

    walker_state_e          r_state;
    word_t                  r_size;
    word_t                  r_cur;
    word_t                  r_prev;
    logic [HOP_CNT_W-1:0]   r_hops;
    logic                   r_req_ready;
    logic                   r_mem_req_valid;
    logic                   r_rsp_valid;
    walk_rsp_t              r_rsp;

    logic                   w_fit;
    logic                   w_null;
    word_t                  w_next;
    logic [HOP_CNT_W-1:0]   w_hops_inc;
    logic                   w_limit;

    // The header is evaluated in the same cycle it is captured, so a hop
    // costs only the ISSUE and WAIT cycles.
    falafel_block_parser u_parser (
        .i_block          (mem_rsp_block_i),
        .i_req_size       (r_size),
        .o_is_big_enough  (w_fit),
        .o_is_null        (w_null),
        .o_next_block_ptr (w_next)
    );

    // Hop count including the header arriving now; sticks at all-ones.
    assign w_hops_inc = (r_hops == {HOP_CNT_W{1'b1}}) ? r_hops
                                                       : r_hops + HOP_CNT_W'(1);

`ifdef FALAFEL_WALK_LIMIT_EN
    localparam logic [HOP_CNT_W-1:0] c_max_hops = HOP_CNT_W'(MAX_HOPS);
    assign w_limit = (w_hops_inc >= c_max_hops);
`else
    assign w_limit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state         <= IDLE;
            r_size          <= '0;
            r_cur           <= NULL_PTR;
            r_prev          <= NULL_PTR;
            r_hops          <= '0;
            r_req_ready     <= 1'b1;
            r_mem_req_valid <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp           <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_size      <= req_size_i;
                        r_cur       <= req_head_ptr_i;
                        r_prev      <= NULL_PTR;
                        r_hops      <= '0;
                        r_req_ready <= 1'b0;
                        if (req_head_ptr_i == NULL_PTR) begin
                            // Empty list: answer without touching memory.
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp       <= '{found:     1'b0,
                                             block_ptr: NULL_PTR,
                                             prev_ptr:  NULL_PTR,
                                             block:     '0,
                                             hops:      '0,
                                             abort:     1'b0};
                        end else begin
                            r_state         <= ISSUE;
                            r_mem_req_valid <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    // Address is r_cur, which only changes in WAIT, so it is
                    // stable for the whole stall.
                    if (mem_req_ready_i) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= WAIT;
                    end
                end

                WAIT: begin
                    if (mem_rsp_valid_i) begin
                        r_hops <= w_hops_inc;
                        if (w_fit) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp       <= '{found:     1'b1,
                                             block_ptr: r_cur,
                                             prev_ptr:  r_prev,
                                             block:     mem_rsp_block_i,
                                             hops:      WALK_HOPS_W'(w_hops_inc),
                                             abort:     1'b0};
                        end else if (w_null || w_limit) begin
                            // List exhausted, or hop budget spent: not found.
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp       <= '{found:     1'b0,
                                             block_ptr: NULL_PTR,
                                             prev_ptr:  NULL_PTR,
                                             block:     '0,
                                             hops:      WALK_HOPS_W'(w_hops_inc),
                                             abort:     !w_null};
                        end else begin
                            r_prev          <= r_cur;
                            r_cur           <= w_next;
                            r_state         <= ISSUE;
                            r_mem_req_valid <= 1'b1;
                        end
                    end
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o     = r_req_ready;
    assign mem_req_valid_o = r_mem_req_valid;
    assign mem_req_addr_o  = r_cur;
    assign rsp_valid_o     = r_rsp_valid;
    assign rsp_found_o     = r_rsp.found;
    assign rsp_block_ptr_o = r_rsp.block_ptr;
    assign rsp_prev_ptr_o  = r_rsp.prev_ptr;
    assign rsp_block_o     = r_rsp.block;
    assign rsp_hops_o      = HOP_CNT_W'(r_rsp.hops);
    assign rsp_abort_o     = r_rsp.abort;

endmodule : falafel_freelist_walker
`default_nettype wire
